// File: rtl/matrix_3x3_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_3x3_gen_pkg
// Description : Shared defaults and counter-width helpers for the 3x3 window
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_3x3_gen_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_IMG_W  = 640;
    localparam int DEF_IMG_H  = 480;

    // Column counter must be able to hold IMG_W itself (end-of-line hold value)
    function automatic int col_cnt_w(input int img_w);
        return $clog2(img_w + 1);
    endfunction

    function automatic int row_cnt_w(input int img_h);
        return (img_h > 1) ? $clog2(img_h) : 1;
    endfunction

    function automatic int lb_addr_w(input int img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_3x3_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_3x3_gen_if
// Description : Pixel-stream input and 3x3 window output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_3x3_gen_if
    import matrix_3x3_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [DATA_W-1:0] per_img_data;

    logic              matrix_frame_vsync;
    logic              matrix_frame_href;
    logic              matrix_frame_clken;
    logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_data,
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );

endinterface
`default_nettype wire

// File: rtl/matrix_3x3_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_3x3_gen_line_buffer
// Description : Simple dual-port line RAM, registered read, read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_3x3_gen_line_buffer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
)(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Contents are deliberately not reset; the window border masking hides them
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/matrix_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : matrix_3x3_gen
// Description : 3x3 neighbourhood generator from a raster pixel stream with
//               two line buffers, border masking and 2-cycle sync alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_3x3_gen
    import matrix_3x3_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
)(
    input  logic             clk,
    input  logic             rst,
    matrix_3x3_gen_if.slave  bus
);

    localparam int c_COL_W  = col_cnt_w(IMG_W);
    localparam int c_ROW_W  = row_cnt_w(IMG_H);
    localparam int c_ADDR_W = lb_addr_w(IMG_W);
    localparam logic [c_COL_W-1:0] c_IMG_W   = c_COL_W'(IMG_W);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(IMG_H - 1);

    logic               r_vsync_d1, r_vsync_d2, r_href_d1, r_href_d2;
    logic               r_armed;
    logic [c_COL_W-1:0] r_col_cnt;
    logic [c_ROW_W-1:0] r_row_cnt;

    logic               w_vsync_rise, w_href_rise, w_href_fall, w_accept;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;

    // Edges are seen in the same cycle so a pixel coinciding with them lands at index 0
    assign w_vsync_rise = bus.per_frame_vsync & ~r_vsync_d1;
    assign w_href_rise  = bus.per_frame_href  & ~r_href_d1;
    assign w_href_fall  = ~bus.per_frame_href & r_href_d1;
    assign w_col        = (w_vsync_rise | w_href_rise) ? '0 : r_col_cnt;
    assign w_row        = w_vsync_rise ? '0 : r_row_cnt;
    assign w_accept     = bus.per_frame_clken & bus.per_frame_href & ~rst &
                          (r_armed | w_vsync_rise) & (w_col < c_IMG_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d1 <= 1'b0;
            r_vsync_d2 <= 1'b0;
            r_href_d1  <= 1'b0;
            r_href_d2  <= 1'b0;
            r_armed    <= 1'b0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
        end else begin
            r_vsync_d1 <= bus.per_frame_vsync;
            r_vsync_d2 <= r_vsync_d1;
            r_href_d1  <= bus.per_frame_href;
            r_href_d2  <= r_href_d1;
            if (w_vsync_rise) begin
                r_armed <= 1'b1;
            end
            if (w_accept) begin
                r_col_cnt <= w_col + c_COL_W'(1);
            end else if (w_vsync_rise | w_href_rise) begin
                r_col_cnt <= '0;
            end
            if (w_vsync_rise) begin
                r_row_cnt <= '0;
            end else if (w_href_fall && r_armed && r_row_cnt != c_ROW_MAX) begin
                r_row_cnt <= r_row_cnt + c_ROW_W'(1);
            end
        end
    end

    // Stage 1: line-buffer read plus registered pixel and border flags
    logic                r_s1_valid, r_s1_c0, r_s1_c01, r_s1_r1, r_s1_r2;
    logic [DATA_W-1:0]   r_s1_pix;
    logic [c_ADDR_W-1:0] r_s1_addr;
    logic [DATA_W-1:0]   w_lb1_q, w_lb0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_c0    <= 1'b0;
            r_s1_c01   <= 1'b0;
            r_s1_r1    <= 1'b0;
            r_s1_r2    <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_c0    <= (w_col == '0);
            r_s1_c01   <= (w_col <= c_COL_W'(1));
            r_s1_r1    <= (w_row != '0);
            r_s1_r2    <= (w_row > c_ROW_W'(1));
            r_s1_pix   <= bus.per_img_data;
            r_s1_addr  <= w_col[c_ADDR_W-1:0];
        end
    end

    matrix_3x3_gen_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (c_ADDR_W)
    ) u_lb1 (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (w_col[c_ADDR_W-1:0]),
        .i_wr_data (bus.per_img_data),
        .i_rd_addr (w_col[c_ADDR_W-1:0]),
        .o_rd_data (w_lb1_q)
    );

    // lb0 is fed from lb1's read port one cycle later, so it trails by one more row
    matrix_3x3_gen_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (c_ADDR_W)
    ) u_lb0 (
        .clk       (clk),
        .i_wr_en   (r_s1_valid),
        .i_wr_addr (r_s1_addr),
        .i_wr_data (w_lb1_q),
        .i_rd_addr (w_col[c_ADDR_W-1:0]),
        .o_rd_data (w_lb0_q)
    );

    // Stage 2: masked column entry into the window shift registers
    logic [DATA_W-1:0] w_row_in [1:3];
    logic [DATA_W-1:0] r_win    [1:3][1:3];
    logic              r_s2_valid;

    always_comb begin
        w_row_in[1] = r_s1_r2 ? w_lb0_q : '0;
        w_row_in[2] = r_s1_r1 ? w_lb1_q : '0;
        w_row_in[3] = r_s1_pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            for (int i = 1; i <= 3; i++) begin
                for (int j = 1; j <= 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                for (int i = 1; i <= 3; i++) begin
                    r_win[i][3] <= w_row_in[i];
                    r_win[i][2] <= r_s1_c0  ? '0 : r_win[i][3];
                    r_win[i][1] <= r_s1_c01 ? '0 : r_win[i][2];
                end
            end
        end
    end

    assign bus.matrix_frame_vsync = r_vsync_d2;
    assign bus.matrix_frame_href  = r_href_d2;
    assign bus.matrix_frame_clken = r_s2_valid;
    assign bus.matrix_p11 = r_win[1][1];
    assign bus.matrix_p12 = r_win[1][2];
    assign bus.matrix_p13 = r_win[1][3];
    assign bus.matrix_p21 = r_win[2][1];
    assign bus.matrix_p22 = r_win[2][2];
    assign bus.matrix_p23 = r_win[2][3];
    assign bus.matrix_p31 = r_win[3][1];
    assign bus.matrix_p32 = r_win[3][2];
    assign bus.matrix_p33 = r_win[3][3];

endmodule
`default_nettype wire
